// File: rtl/bus_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin bus scheduler.
// The destination ID occupies the top ID_W bits of every packet.
package bus_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } state_e;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;

endpackage

// File: rtl/bus_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: finds the first request after the pointer, with wrap.
// Returns both a one-hot grant and its index; any is low when there are no requests.
module rr_pick
    import bus_rr_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Search ptr+1, ptr+2, ... wrapping; the first hit wins
    always_comb begin
        int j;
        logic [IW-1:0] j_idx;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        j_idx     = '0;
        for (int k = 1; k <= N; k++) begin
            j     = (int'(ptr) + k) % N;
            j_idx = IW'(j);
            if (!any && req[j_idx]) begin
                any       = 1'b1;
                grant_idx = j_idx;
                grant_oh  = N'(1'b1) << j_idx;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: pops one packet per three cycles from agent FIFOs
// and pushes it to its unicast destination, to all other agents, or drops it.
module bus_rr_scheduler
    import bus_rr_scheduler_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic                            busy,
    output logic [7:0]                      drop_cnt
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(drvrs - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        winner_q, winner_d;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic [pckg_sz-1:0]   data_q, data_d;
    logic                 busy_q, busy_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic [drvrs-1:0]     pick_oh_s;
    logic [IW-1:0]        pick_idx_s;
    logic                 pick_any_s;
    logic [pckg_sz-1:0]   head_s;
    logic [ID_W-1:0]      head_id_s;
    logic [drvrs-1:0]     lane_mask_s;
    logic                 drop_s;

    rr_pick #(
        .N  (drvrs),
        .IW (IW)
    ) u_rr_pick (
        .req       (pndng),
        .ptr       (last_grant_q),
        .grant_oh  (pick_oh_s),
        .grant_idx (pick_idx_s),
        .any       (pick_any_s)
    );

    // Decode the granted head word into destination lanes or a drop
    always_comb begin
        head_s      = D_pop[winner_q];
        head_id_s   = head_s[pckg_sz-1 -: ID_W];
        lane_mask_s = '0;
        drop_s      = 1'b0;
        if (32'(head_id_s) < 32'(drvrs)) begin
            lane_mask_s = drvrs'(1'b1) << head_id_s;
        end else if (head_id_s == broadcast) begin
            lane_mask_s = ~(drvrs'(1'b1) << winner_q);
        end else begin
            drop_s = 1'b1;
        end
    end

    // Next-state logic; pop is set on entry to GRANT, push on entry to DELIVER
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        pop_d        = '0;
        push_d       = '0;
        data_d       = data_q;
        drop_cnt_d   = drop_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    winner_d = pick_idx_s;
                    pop_d    = pick_oh_s;
                    state_d  = GRANT;
                end else begin
                    state_d  = IDLE;
                end
            end
            GRANT: begin
                last_grant_d = winner_q;
                data_d       = head_s;
                push_d       = lane_mask_s;
                if (drop_s && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
                state_d = DELIVER;
            end
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_q     <= '0;
            last_grant_q <= LAST_RST;
            pop_q        <= '0;
            push_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            pop_q        <= pop_d;
            push_q       <= push_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = {drvrs{data_q}};
    assign busy     = busy_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: a transaction-level model predicts each pop
// and delivery; a monitor compares whenever the scheduler pops or pushes.
module tb_bus_rr_scheduler;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [3:0]        pndng = 4'b0000;
    logic [3:0][15:0]  D_pop = '0;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [3:0][15:0]  D_push;
    logic              busy;
    logic [7:0]        drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // reference model state
    int          m_phase = 0;   // 0 idle, 1 popping, 2 delivering
    int          m_last  = 3;
    logic [1:0]  m_win   = 2'd0;
    int          m_drops = 0;
    logic [3:0]  exp_pop_q[$];
    logic [19:0] exp_del_q[$];  // {lane mask, word}

    logic [3:0]  pop_log[$];
    int          pop_cyc[$];
    logic [3:0]  last_push = 4'b0000;
    logic [15:0] last_word = 16'h0000;

    bus_rr_scheduler #(
        .drvrs     (4),
        .pckg_sz   (16),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // round-robin rule: first requester after the last grant, wrapping
    function automatic int rr_next(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (req[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Transaction model: one packet takes pick, pop, deliver on three edges
    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_last  = 3;
            m_drops = 0;
            exp_pop_q.delete();
            exp_del_q.delete();
        end else if (m_phase == 0) begin
            if (pndng != 4'b0000) begin
                int w;
                w = rr_next(pndng, m_last);
                m_win = w[1:0];
                exp_pop_q.push_back(4'b0001 << m_win);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            logic [15:0] word;
            logic [7:0]  id;
            logic [3:0]  mask;
            word   = D_pop[m_win];
            id     = word[15:8];
            m_last = int'(m_win);
            if (id < 8'd4)        mask = 4'b0001 << id;
            else if (id == 8'hFF) mask = 4'b1111 & ~(4'b0001 << m_win);
            else                  mask = 4'b0000;
            if (mask == 4'b0000) begin
                if (m_drops < 255) m_drops = m_drops + 1;
            end else begin
                exp_del_q.push_back({mask, word});
            end
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    // Monitor: compares DUT activity against the expectation queues
    always @(posedge clk) begin
        #2;
        cyc++;
        if (pop != 4'b0000) begin
            pop_log.push_back(pop);
            pop_cyc.push_back(cyc);
            if (exp_pop_q.size() == 0) flag_fail("pop_unexpected", 64'(pop));
            else chk("pop_lane", 64'(pop), 64'(exp_pop_q.pop_front()));
        end
        if (push != 4'b0000) begin
            last_push = push;
            last_word = D_push[0];
            if (exp_del_q.size() == 0) begin
                flag_fail("push_unexpected", 64'(push));
            end else begin
                logic [19:0] e;
                e = exp_del_q.pop_front();
                chk("push_mask", 64'(push), 64'(e[19:16]));
                for (int i = 0; i < 4; i++) chk("d_push_lane", 64'(D_push[i]), 64'(e[15:0]));
            end
        end
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        if ((pop & push) != 4'b0000 || !$onehot0(pop)) flag_fail("pop_push_overlap", 64'({pop, push}));
    end

    task automatic check_zero_outputs();
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_push", 64'(push), 64'd0);
        chk("rst_d_push", 64'(D_push), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic one_packet(input int agent, input logic [15:0] word);
        @(negedge clk);
        D_pop[agent] = word;
        pndng = 4'b0001 << agent;
        @(negedge clk);
        pndng = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic random_inputs();
        pndng = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) begin
            int sel;
            logic [7:0] id;
            sel = $urandom_range(0, 6);
            if (sel < 4)       id = 8'(sel);
            else if (sel == 4) id = 8'hFF;
            else if (sel == 5) id = 8'h07;
            else               id = 8'($urandom_range(0, 255));
            D_pop[i] = {id, 8'($urandom_range(0, 255))};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        #2 reset = 1'b1;
        #1 check_zero_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // unicast to agent 2
        one_packet(0, 16'h0255);
        chk("uni_push", 64'(last_push), 64'(4'b0100));
        chk("uni_word", 64'(last_word), 64'(16'h0255));

        // broadcast from agent 1 skips the sender
        one_packet(1, 16'hFFAB);
        chk("bcast_push", 64'(last_push), 64'(4'b1101));
        chk("bcast_word", 64'(last_word), 64'(16'hFFAB));

        // invalid ID is dropped and counted, saturating at 255
        chk("drop_start", 64'(drop_cnt), 64'd0);
        one_packet(3, 16'h07AA);
        chk("drop_one", 64'(drop_cnt), 64'd1);
        @(negedge clk);
        pndng = 4'b1000;
        repeat (900) @(negedge clk);
        pndng = 4'b0000;
        repeat (4) @(negedge clk);
        chk("drop_sat", 64'(drop_cnt), 64'd255);

        // self-addressed unicast
        one_packet(2, 16'h025A);
        chk("self_push", 64'(last_push), 64'(4'b0100));
        chk("self_word", 64'(last_word), 64'(16'h025A));

        // all requesting: grant order 0,1,2,3,0 every third cycle
        do_reset();
        D_pop[0] = 16'h0111; D_pop[1] = 16'h0222;
        D_pop[2] = 16'h0333; D_pop[3] = 16'h0044;
        pop_log.delete(); pop_cyc.delete();
        pndng = 4'b1111;
        repeat (15) @(negedge clk);
        pndng = 4'b0000;
        repeat (4) @(negedge clk);
        chk("rr_count", 64'(pop_log.size() >= 5), 64'd1);
        if (pop_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 64'(pop_log[k]), 64'(4'b0001 << (k % 4)));
            for (int k = 0; k < 4; k++) chk("rr_spacing", 64'(pop_cyc[k+1] - pop_cyc[k]), 64'd3);
        end

        // reset during the pop cycle abandons the packet
        @(negedge clk);
        pndng = 4'b1111;
        waited = 0;
        do begin
            @(posedge clk);
            #3;
            waited++;
        end while (pop == 4'b0000 && waited < 10);
        chk("grant_seen", 64'(pop != 4'b0000), 64'd1);
        reset = 1'b1;
        #1;
        check_zero_outputs();
        @(negedge clk);
        @(negedge clk);
        pop_log.delete();
        reset = 1'b0;
        waited = 0;
        while (pop_log.size() == 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("post_rst_grant", 64'(pop_log.size() > 0 ? pop_log[0] : 4'b0000), 64'(4'b0001));
        pndng = 4'b0000;
        repeat (4) @(negedge clk);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            random_inputs();
        end
        pndng = 4'b0000;
        repeat (5) @(negedge clk);
        chk("pops_outstanding", 64'(exp_pop_q.size()), 64'd0);
        chk("deliveries_outstanding", 64'(exp_del_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
